// File: rtl/moka_prog_loader_pkg.sv
// rtl/moka_prog_loader_pkg.sv - shared constants and helpers for the moka program loader
// Purpose: state encodings, frame geometry and checksum width used by the loader and its byte packer.
package moka_prog_loader_pkg;

   typedef logic [2:0] state_t;

   // Header and payload words share the same 4-byte little-endian packing.
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned CSUM_W         = 8;

   localparam state_t ST_LEN   = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_CSUM  = 3'd2;
   localparam state_t ST_RUN   = 3'd3;
   localparam state_t ST_ERROR = 3'd4;

   // States in which the byte stream is being consumed.
   function automatic logic is_rx_state(input state_t st);
      return (st == ST_LEN) || (st == ST_LOAD) || (st == ST_CSUM);
   endfunction

endpackage

// File: rtl/moka_byte_packer.sv
// rtl/moka_byte_packer.sv - 8-to-32 bit little-endian byte packer with a one-deep word buffer
// Purpose: assembles accepted bytes into words (first byte = LSB) and holds a completed word
//          for one write cycle while the next word keeps filling.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   en           global enable; 0 freezes all state
//   clear        drop partial word and any pending buffered word
//   in_valid     a byte is accepted this cycle
//   in_data      accepted byte
//   word_load    buffer the completed word as a pending write
//   word_done    combinational: this byte completes a word
//   word_next    combinational: the word being completed by this byte
//   word         buffered word
//   word_valid   buffered word is pending (one cycle per word while en=1)
module moka_byte_packer
   import moka_prog_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        word_load,
   output logic        word_done,
   output logic [31:0] word_next,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] data_q, data_d;
   logic [31:0] word_q, word_d;
   logic        word_valid_q, word_valid_d;

   assign word_done = in_valid && (byte_idx_q == LAST_IDX);
   // Bytes shift in from the top, so after three bytes data_q = {b2, b1, b0}.
   assign word_next = {in_data, data_q};

   always_comb begin
      byte_idx_d   = byte_idx_q;
      data_d       = data_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      if (clear) begin
         byte_idx_d = '0;
         data_d     = '0;
      end else if (in_valid) begin
         byte_idx_d = byte_idx_q + 2'd1;  // wraps to 0 after the last byte of a word
         data_d     = {in_data, data_q[23:8]};
         if (word_done && word_load) begin
            word_d       = word_next;
            word_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_idx_q   <= '0;
         data_q       <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
      end else if (en) begin
         byte_idx_q   <= byte_idx_d;
         data_q       <= data_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;

endmodule

// File: rtl/moka_prog_loader.sv
// rtl/moka_prog_loader.sv - boot-time program loader feeding the moka core instruction memory
// Purpose: receives a frame (4-byte LE word count N, N LE words, 1-byte XOR checksum) on a byte
//          stream, writes the words to instruction memory and releases the core once the image
//          checksum matches.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   en                 global enable; 0 freezes all state
//   reload             one-cycle restart request back to header reception
//   s_valid/s_data     byte stream in
//   s_ready            byte accepted when s_valid & s_ready
//   instr_mem_*        instruction memory write port (byte address, word, strobe)
//   core_rstn/core_en  core reset release and enable, high only once the image is verified
//   done               image verified
//   error              sticky fault: length overflow or checksum mismatch
module moka_prog_loader
   import moka_prog_loader_pkg::*;
#(
   parameter int unsigned               DATA_WIDTH        = 32,
   parameter int unsigned               INST_MEM_CAPACITY = 1024,
   parameter logic [DATA_WIDTH-1:0]     ADDR_STEP         = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  reload,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] instr_mem_address,
   output logic [DATA_WIDTH-1:0] instr_mem_data,
   output logic                  instr_mem_we,
   output logic                  core_rstn,
   output logic                  core_en,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned CNT_W = $clog2(INST_MEM_CAPACITY + 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;
   logic [CNT_W-1:0]        len_q, len_d;
   logic [CSUM_W-1:0]       csum_q, csum_d;
   logic [DATA_WIDTH-1:0]   addr_q, addr_d;

   logic                    xfer;
   logic                    pk_valid;
   logic                    pk_done;
   logic [31:0]             pk_next;
   logic [31:0]             pk_word;
   logic                    pk_word_valid;

   assign s_ready  = en && is_rx_state(state_q);
   // A byte offered together with reload is dropped: reload wins.
   assign xfer     = s_valid && s_ready && !reload;
   assign pk_valid = xfer && ((state_q == ST_LEN) || (state_q == ST_LOAD));

   moka_byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .clear      (reload),
      .in_valid   (pk_valid),
      .in_data    (s_data),
      .word_load  (state_q == ST_LOAD),
      .word_done  (pk_done),
      .word_next  (pk_next),
      .word       (pk_word),
      .word_valid (pk_word_valid)
   );

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      csum_d     = csum_q;
      addr_d     = addr_q;
      if (reload) begin
         state_d    = ST_LEN;
         word_cnt_d = '0;
         len_d      = '0;
         csum_d     = '0;
         addr_d     = '0;
      end else if (xfer) begin
         case (state_q)
            ST_LEN: begin
               csum_d = csum_q ^ s_data;
               if (pk_done) begin
                  word_cnt_d = '0;
                  if (pk_next > INST_MEM_CAPACITY) begin
                     state_d = ST_ERROR;
                  end else if (pk_next == '0) begin
                     state_d = ST_CSUM;
                  end else begin
                     state_d = ST_LOAD;
                     len_d   = pk_next[CNT_W-1:0];
                  end
               end
            end
            ST_LOAD: begin
               csum_d = csum_q ^ s_data;
               if (pk_done) begin
                  // Address is latched alongside the buffered word so both appear on the write cycle.
                  addr_d     = DATA_WIDTH'(word_cnt_q) * ADDR_STEP;
                  word_cnt_d = word_cnt_q + CNT_W'(1);
                  if (word_cnt_d == len_q) begin
                     state_d = ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               state_d = (s_data == csum_q) ? ST_RUN : ST_ERROR;
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_LEN;
         word_cnt_q <= '0;
         len_q      <= '0;
         csum_q     <= '0;
         addr_q     <= '0;
      end else if (en) begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
      end
   end

   // A buffered word stays pending while en=0 and is written once en returns.
   assign instr_mem_we      = pk_word_valid && en;
   assign instr_mem_data    = pk_word;
   assign instr_mem_address = addr_q;
   assign core_rstn         = (state_q == ST_RUN);
   assign core_en           = (state_q == ST_RUN);
   assign done              = (state_q == ST_RUN);
   assign error             = (state_q == ST_ERROR);

endmodule

// File: tb/tb_moka_prog_loader.sv
// tb/tb_moka_prog_loader.sv - self-checking bench for the moka program loader
module tb_moka_prog_loader;

   logic        clk = 1'b0;
   logic        rst, en, reload, s_valid;
   logic [7:0]  s_data;
   logic        s_ready, instr_mem_we, core_rstn, core_en, done, error;
   logic [31:0] instr_mem_address, instr_mem_data;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0]  tx_q[$];
   logic [31:0] w_q[$];
   logic [31:0] exp_addr[$], exp_data[$];
   logic [31:0] obs_addr[$], obs_data[$];
   int          overlap = 0;
   int          obs_base = 0;
   int          overlap_base = 0;
   logic        last_pre_done;

   always #5 clk = ~clk;

   moka_prog_loader dut (
      .clk               (clk),
      .rst               (rst),
      .en                (en),
      .reload            (reload),
      .s_valid           (s_valid),
      .s_data            (s_data),
      .s_ready           (s_ready),
      .instr_mem_address (instr_mem_address),
      .instr_mem_data    (instr_mem_data),
      .instr_mem_we      (instr_mem_we),
      .core_rstn         (core_rstn),
      .core_en           (core_en),
      .done              (done),
      .error             (error)
   );

   always @(negedge clk) begin
      if (instr_mem_we === 1'b1) begin
         obs_addr.push_back(instr_mem_address);
         obs_data.push_back(instr_mem_data);
         if (core_rstn === 1'b1) overlap++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference frame: LE count, LE words, XOR of all preceding bytes (optionally corrupted).
   task automatic build(input logic [31:0] n, input logic [7:0] bad);
      logic [7:0] c;
      c = 8'h00;
      tx_q.delete(); exp_addr.delete(); exp_data.delete();
      for (int b = 0; b < 4; b++) tx_q.push_back(n[8*b +: 8]);
      for (int i = 0; i < w_q.size(); i++) begin
         for (int b = 0; b < 4; b++) tx_q.push_back(w_q[i][8*b +: 8]);
         exp_addr.push_back(32'(i * 4));
         exp_data.push_back(w_q[i]);
      end
      foreach (tx_q[k]) c = c ^ tx_q[k];
      tx_q.push_back(c ^ bad);
   endtask

   task automatic send(input int gap_pct, input int drop_idx);
      int i = 0;
      int budget = 0;
      bit dropped = 0;
      while (i < tx_q.size() && budget < 3000) begin
         @(negedge clk);
         budget++;
         if (i == drop_idx && !dropped) begin
            dropped = 1; en = 1'b0; s_valid = 1'b1; s_data = tx_q[i];
            repeat (3) begin
               #1;
               chk("ready_en0", 32'(s_ready), 0);
               chk("we_en0", 32'(instr_mem_we), 0);
               @(negedge clk);
            end
            en = 1'b1;
         end
         s_valid = ($urandom_range(99) >= gap_pct);
         s_data  = tx_q[i];
         #1;
         if (s_valid && s_ready) begin
            last_pre_done = done;
            i++;
         end
         @(posedge clk);
         #1;
         s_valid = 1'b0;
      end
      chk("bytes_sent", 32'(i), 32'(tx_q.size()));
   endtask

   task automatic status(input string tag, input logic exp_done, input logic exp_err);
      chk({tag, "_done"}, 32'(done), 32'(exp_done));
      chk({tag, "_core_rstn"}, 32'(core_rstn), 32'(exp_done));
      chk({tag, "_core_en"}, 32'(core_en), 32'(exp_done));
      chk({tag, "_error"}, 32'(error), 32'(exp_err));
      chk({tag, "_s_ready"}, 32'(s_ready), 32'(!(exp_done || exp_err)));
   endtask

   task automatic cmp_writes(input string tag);
      int n_obs;
      n_obs = obs_addr.size() - obs_base;
      chk({tag, "_nwr"}, 32'(n_obs), 32'(exp_addr.size()));
      for (int i = 0; i < exp_addr.size() && i < n_obs; i++) begin
         chk({tag, "_addr"}, obs_addr[obs_base + i], exp_addr[i]);
         chk({tag, "_data"}, obs_data[obs_base + i], exp_data[i]);
      end
      chk({tag, "_we_in_run"}, 32'(overlap - overlap_base), 0);
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1; s_valid = 1'b1; s_data = 8'hA5;
      @(posedge clk);
      #1;
      reload = 1'b0; s_valid = 1'b0;
      obs_base = obs_addr.size();
      overlap_base = overlap;
   endtask

   task automatic happy_words();
      w_q.delete();
      w_q.push_back(32'h00500093);
      w_q.push_back(32'h00A00113);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] bad;
      rst = 1'b1; en = 1'b1; reload = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      status("reset", 1'b0, 1'b0);
      chk("reset_we", 32'(instr_mem_we), 0);
      chk("reset_addr", instr_mem_address, 0);
      chk("reset_data", instr_mem_data, 0);

      // Happy path
      happy_words(); build(2, 8'h00); send(0, -1);
      chk("happy_done_before_csum", 32'(last_pre_done), 0);
      status("happy", 1'b1, 1'b0);
      cmp_writes("happy");

      // Bad checksum
      do_reload();
      status("after_reload", 1'b0, 1'b0);
      happy_words(); build(2, 8'h01); send(0, -1);
      status("badcsum", 1'b0, 1'b1);
      cmp_writes("badcsum");
      repeat (3) @(negedge clk);
      chk("badcsum_sticky", 32'(error), 1);

      // Overflow: N = 1025, header only
      do_reload();
      w_q.delete(); build(1025, 8'h00); void'(tx_q.pop_back());
      send(0, -1);
      status("overflow", 1'b0, 1'b1);
      cmp_writes("overflow");

      // Largest legal length is accepted into LOAD
      do_reload();
      w_q.delete(); build(1024, 8'h00); void'(tx_q.pop_back());
      send(0, -1);
      status("cap1024", 1'b0, 1'b0);

      // Empty image
      do_reload();
      w_q.delete(); build(0, 8'h00); send(0, -1);
      status("n0", 1'b1, 1'b0);
      cmp_writes("n0");

      // Stalls plus en dropped mid-word
      do_reload();
      happy_words(); build(2, 8'h00); send(40, 6);
      status("stall", 1'b1, 1'b0);
      cmp_writes("stall");

      // reload after 5 bytes, then a full image
      do_reload();
      happy_words(); build(2, 8'h00);
      while (tx_q.size() > 5) void'(tx_q.pop_back());
      send(0, -1);
      chk("partial_nwr", 32'(obs_addr.size() - obs_base), 0);
      do_reload();
      status("reload", 1'b0, 1'b0);
      happy_words(); build(2, 8'h00); send(20, -1);
      status("reload_full", 1'b1, 1'b0);
      cmp_writes("reload_full");

      // Random images
      for (int t = 0; t < 6; t++) begin
         do_reload();
         w_q.delete();
         n = int'($urandom_range(1, 8));
         for (int k = 0; k < n; k++) w_q.push_back($urandom());
         bad = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
         build(32'(n), bad);
         send(30, int'($urandom_range(0, tx_q.size() - 1)));
         status("rand", bad == 8'h00, bad != 8'h00);
         cmp_writes("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
